// File: rtl/cd_rx_byte.sv
// Purpose : async serial byte receiver (8N1, LSB first) with two selectable bit divisors.
// Latency : rx to rx_s is SYNC_STAGES clk (+2 with CD_RX_GLITCH_FILTER_EN); rx_valid/rx_err one clk after the mid stop-bit sample.
// Backpres: none; every frame is reported as a single one-clk pulse and data is overwritten on the next stop sample.
//
// Ports:
//   clk, reset        sole clock; synchronous active-high reset
//   rx                asynchronous serial line, idle high
//   div_ls / div_hs   bit period = div+1 clk; sel=1 picks div_hs; latched at frame start
//   data              last received byte (held until the next stop sample)
//   rx_valid / rx_err one-clk pulses: good stop bit / stop bit low
//   busy              high while a frame is in progress
// Optional: define CD_RX_GLITCH_FILTER_EN for a 3-tap majority filter after the synchronizer.
module cd_rx_byte #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic [15:0] div_ls,
    input  logic [15:0] div_hs,
    input  logic        sel,
    output logic [7:0]  data,
    output logic        rx_valid,
    output logic        rx_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev;
    logic                   fall;
    logic [15:0]            cnt;
    logic [15:0]            div_lat;
    logic [15:0]            div_sel;
    logic [2:0]             bit_idx;
    logic [7:0]             shift_q;
    logic                   samp;
    logic                   start_go;
    logic                   samp_start;
    logic                   samp_data;
    logic                   samp_stop;

    // Synchronizer presets to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

`ifdef CD_RX_GLITCH_FILTER_EN
    // Three-tap history of the synchronizer output; the majority needs two
    // taps to agree, so a lone one-clk glitch never reaches rx_s.
    logic [2:0] flt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            flt_q <= '1;
        end else begin
            flt_q <= {flt_q[1:0], sync_q[SYNC_STAGES-1]};
        end
    end

    assign rx_s = (flt_q[0] & flt_q[1]) | (flt_q[0] & flt_q[2]) | (flt_q[1] & flt_q[2]);
`else
    assign rx_s = sync_q[SYNC_STAGES-1];
`endif

    // Edge history also presets high: only a genuine 1->0 transition starts a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= rx_s;
        end
    end

    assign fall    = rx_prev & ~rx_s;
    assign div_sel = sel ? div_hs : div_ls;
    // Half-bit sample point; cnt restarts at every bit boundary.
    assign samp    = (state != IDLE) && (cnt == {1'b0, div_lat[15:1]});

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (samp) begin
                    // A start bit that is high again at mid-bit was noise.
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (samp && (bit_idx == 3'd7)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Leave mid stop bit so the next start edge is never missed.
                if (samp) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output/strobe decode
    always_comb begin
        start_go   = (state == IDLE) && fall;
        samp_start = (state == START) && samp;
        samp_data  = (state == DATA) && samp;
        samp_stop  = (state == STOP) && samp;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            div_lat  <= 16'd2;
            bit_idx  <= '0;
            shift_q  <= '0;
            data     <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_valid <= samp_stop & rx_s;
            rx_err   <= samp_stop & ~rx_s;
            busy     <= (state_nxt != IDLE);

            if (state == IDLE || cnt >= div_lat) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end

            // Divisor is frozen for the whole frame; 0 and 1 are too short
            // to place a half-bit sample, so they are raised to 2.
            if (start_go) begin
                div_lat <= (div_sel < 16'd2) ? 16'd2 : div_sel;
                bit_idx <= '0;
            end

            // Line order is LSB first, so each new bit enters at the MSB.
            if (samp_data) begin
                shift_q <= {rx_s, shift_q[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end

            if (samp_stop) begin
                data <= shift_q;
            end
        end
    end

    // samp_start only steers the FSM; kept for readability of the strobe set.
    logic unused_ok;
    assign unused_ok = samp_start;

endmodule

// File: tb/tb_cd_rx_byte.sv
// Purpose : self-checking bench for cd_rx_byte: directed frames plus randomized traffic.
// Latency : reference model predicts every output after each clk edge from the frame timing rules.
// Backpres: n/a (bench drives rx freely; DUT has no flow control).
module tb_cd_rx_byte;

    localparam int S    = 2;
    localparam int MAXC = 100000;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [15:0] div_ls;
    logic [15:0] div_hs;
    logic        sel;
    logic [7:0]  data;
    logic        rx_valid;
    logic        rx_err;
    logic        busy;

    always #5 clk = ~clk;

    cd_rx_byte #(.SYNC_STAGES(S)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .div_ls   (div_ls),
        .div_hs   (div_hs),
        .sel      (sel),
        .data     (data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Line history per clk edge; rx_s is the line delayed by S edges, forced
    // high when reset was seen inside that window.
    bit   rxv  [MAXC];
    bit   rstv [MAXC];
    int   cyc = 0;

    bit         m_ok   = 1'b0;
    bit         m_act  = 1'b0;
    bit         ev_valid = 1'b0;
    bit         ev_err   = 1'b0;
    int         m_t0;
    int         m_D;
    int         off;
    int         k;
    logic [15:0] dsel;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] m_data = 8'h00;

    function automatic bit rxs_at(input int c);
        if (c - S < 0) return 1'b1;
        for (int j = c - S; j < c; j++) begin
            if (rstv[j]) return 1'b1;
        end
        return rxv[c - S];
    endfunction

    function automatic bit prev_at(input int c);
        if (c < 1 || rstv[c-1]) return 1'b1;
        return rxs_at(c - 1);
    endfunction

    always @(posedge clk) begin
        if (cyc < MAXC - 1) begin
            rxv[cyc]  = (rx === 1'b1);
            rstv[cyc] = (reset === 1'b1);
            ev_valid  = 1'b0;
            ev_err    = 1'b0;
            if (reset === 1'b1) begin
                m_ok   = 1'b1;
                m_act  = 1'b0;
                m_data = 8'h00;
            end else if (!m_act) begin
                // Frame begins on a 1->0 of rx_s; divisor captured now.
                if (prev_at(cyc) && !rxs_at(cyc)) begin
                    m_act  = 1'b1;
                    m_t0   = cyc;
                    dsel   = sel ? div_hs : div_ls;
                    m_D    = (dsel < 16'd2) ? 2 : int'(dsel);
                    m_byte = 8'h00;
                end
            end else begin
                // Sample k (0=start, 1..8=data, 9=stop) lands at
                // t0 + 1 + D/2 + k*(D+1).
                off = cyc - m_t0 - 1 - (m_D / 2);
                if (off >= 0 && (off % (m_D + 1)) == 0) begin
                    k = off / (m_D + 1);
                    if (k == 0) begin
                        if (rxs_at(cyc)) m_act = 1'b0;
                    end else if (k <= 8) begin
                        m_byte[k-1] = rxs_at(cyc);
                    end else begin
                        m_data   = m_byte;
                        ev_valid = rxs_at(cyc);
                        ev_err   = !rxs_at(cyc);
                        m_act    = 1'b0;
                    end
                end
            end
            cyc++;
        end
    end

    // ---------------- compare + monitor ----------------
    int        nvalid   = 0;
    int        nerr     = 0;
    bit        saw_busy = 1'b0;
    logic [7:0] vq[$];

    always @(negedge clk) begin
        if (m_ok) begin
            chk("cyc_rx_valid", 32'(rx_valid), 32'(ev_valid));
            chk("cyc_rx_err",   32'(rx_err),   32'(ev_err));
            chk("cyc_busy",     32'(busy),     32'(m_act));
            chk("cyc_data",     32'(data),     32'(m_data));
        end
        if (rx_valid === 1'b1) begin
            nvalid++;
            vq.push_back(data);
        end
        if (rx_err === 1'b1) nerr++;
        if (busy === 1'b1) saw_busy = 1'b1;
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bit 0 = start, 1..8 = data LSB first, 9 = stop. chg_at toggles sel and
    // scrambles the divisors at that bit; rst_at pulses reset one clk into
    // that bit and then returns the line to idle.
    task automatic send_frame(input logic [7:0] b, input logic stopv, input int per,
                              input int chg_at, input int rst_at);
        for (int i = 0; i < 10; i++) begin
            if (i == chg_at) begin
                sel    = ~sel;
                div_ls = 16'($urandom_range(0, 15));
                div_hs = 16'($urandom_range(0, 15));
            end
            rx = (i == 0) ? 1'b0 : (i == 9) ? stopv : b[i-1];
            for (int j = 0; j < per; j++) begin
                if (i == rst_at && j == 1) begin
                    reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    rx    = 1'b1;
                    return;
                end
                @(negedge clk);
            end
        end
    endtask

    int v0, e0, op, per, chg, rst_at;
    logic [15:0] d;
    logic        stopv;

    initial begin
        reset  = 1'b1;
        rx     = 1'b1;
        sel    = 1'b0;
        div_ls = 16'd9;
        div_hs = 16'd3;
        idle(4);
        chk("reset_data",  32'(data),     32'h00);
        chk("reset_busy",  32'(busy),     32'h0);
        chk("reset_valid", 32'(rx_valid), 32'h0);
        chk("reset_err",   32'(rx_err),   32'h0);
        reset = 1'b0;
        idle(5);

        // 0x55 at 10 clk/bit
        v0 = nvalid; e0 = nerr;
        send_frame(8'h55, 1'b1, 10, -1, -1);
        idle(12);
        chk("f55_valid_cnt", 32'(nvalid - v0), 32'd1);
        chk("f55_err_cnt",   32'(nerr - e0),   32'd0);
        chk("f55_data",      32'(data),        32'h55);
        chk("f55_model",     32'(m_data),      32'h55);
        chk("f55_busy",      32'(busy),        32'h0);

        // 3-clk low glitch: false start
        v0 = nvalid; e0 = nerr;
        saw_busy = 1'b0;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(10);
        chk("glitch_busy_seen", 32'(saw_busy),    32'h1);
        chk("glitch_busy_low",  32'(busy),        32'h0);
        chk("glitch_pulses",    32'(nvalid - v0 + nerr - e0), 32'd0);

        // 0xA5 with low stop, then break
        v0 = nvalid; e0 = nerr;
        send_frame(8'hA5, 1'b0, 10, -1, -1);
        idle(3);
        saw_busy = 1'b0;
        idle(50);
        chk("brk_err_cnt",   32'(nerr - e0),   32'd1);
        chk("brk_valid_cnt", 32'(nvalid - v0), 32'd0);
        chk("brk_data",      32'(data),        32'hA5);
        chk("brk_no_frame",  32'(saw_busy),    32'h0);
        rx = 1'b1;
        idle(5);
        v0 = nvalid;
        send_frame(8'h5A, 1'b1, 10, -1, -1);
        idle(12);
        chk("brk_recover_cnt",  32'(nvalid - v0), 32'd1);
        chk("brk_recover_data", 32'(data),        32'h5A);

        // high-speed divisor, sel toggled mid-frame
        div_hs = 16'd3; div_ls = 16'd9; sel = 1'b1;
        v0 = nvalid;
        send_frame(8'hC3, 1'b1, 4, 4, -1);
        idle(12);
        chk("hs_valid_cnt", 32'(nvalid - v0), 32'd1);
        chk("hs_data",      32'(data),        32'hC3);

        // back-to-back 0x00, 0xFF
        sel = 1'b0; div_ls = 16'd9;
        vq.delete();
        send_frame(8'h00, 1'b1, 10, -1, -1);
        send_frame(8'hFF, 1'b1, 10, -1, -1);
        idle(12);
        chk("b2b_cnt", 32'(vq.size()), 32'd2);
        if (vq.size() == 2) begin
            chk("b2b_first",  32'(vq[0]), 32'h00);
            chk("b2b_second", 32'(vq[1]), 32'hFF);
        end

        // reset during data bit 4
        v0 = nvalid; e0 = nerr;
        send_frame(8'h96, 1'b1, 10, -1, 5);
        idle(30);
        chk("rst_pulses", 32'(nvalid - v0 + nerr - e0), 32'd0);
        chk("rst_data",   32'(data), 32'h00);
        chk("rst_busy",   32'(busy), 32'h0);
        v0 = nvalid;
        send_frame(8'h3C, 1'b1, 10, -1, -1);
        idle(12);
        chk("rst_next_cnt",  32'(nvalid - v0), 32'd1);
        chk("rst_next_data", 32'(data),        32'h3C);

        // randomized traffic, checked cycle by cycle against the model
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 19);
            if (op < 2) begin
                rx = 1'b0;
                idle($urandom_range(1, 4));
                rx = 1'b1;
                idle($urandom_range(0, 15));
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    rx = 1'b1;
                    idle($urandom_range(1, 6));
                end
                div_ls = 16'($urandom_range(0, 12));
                div_hs = 16'($urandom_range(0, 12));
                sel    = 1'($urandom_range(0, 1));
                d      = sel ? div_hs : div_ls;
                per    = ((d < 16'd2) ? 2 : int'(d)) + 1;
                stopv  = ($urandom_range(0, 9) != 0);
                chg    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1;
                rst_at = (op == 2) ? int'($urandom_range(1, 8)) : -1;
                send_frame(8'($urandom_range(0, 255)), stopv, per, chg, rst_at);
            end
        end
        rx = 1'b1;
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cd_rx_byte.md
CD_RX_BYTE -- requirements
Module: cd_rx_byte

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of rx synchronizer flops (min 2).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port div_ls  input  16  low-speed divisor; bit period = div+1 clk.
REQ-006 SHALL have port div_hs  input  16  high-speed divisor.
REQ-007 SHALL have port sel  input  1  1 selects div_hs, 0 selects div_ls.
REQ-008 SHALL have port data  output  8  last received byte.
REQ-009 SHALL have port rx_valid  output  1  one-clk pulse, good frame in data.
REQ-010 SHALL have port rx_err  output  1  one-clk pulse, framing error (stop bit low).
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-012 rx SHALL pass through SYNC_STAGES flops, giving rx_s; all decisions use rx_s only.
REQ-013 SHALL implement states IDLE, START, DATA, STOP; busy = (state != IDLE), registered.
REQ-014 IDLE -> START only on rx_s falling edge (previous 1, current 0); low level alone never starts a frame.
REQ-015 On START entry: 16-bit bit counter cnt <= 0; div_lat <= (sel ? div_hs : div_ls); bit index <= 0.
REQ-016 div_lat SHALL hold for the whole frame; sel, div_ls, div_hs changes mid-frame are ignored.
REQ-017 div_lat values 0 or 1 SHALL be latched as 2.
REQ-018 cnt increments every clk in non-IDLE states; when cnt >= div_lat, cnt <= 0 (bit boundary).
REQ-019 Sample point SHALL be cnt == div_lat[15:1] (half bit).
REQ-020 START sample: rx_s = 1 -> false start, return to IDLE, no output pulse; rx_s = 0 -> DATA.
REQ-021 DATA: each sample shifts rx_s into shift-register MSB (LSB-first line order); after 8th sample -> STOP.
REQ-022 STOP sample: data <= shift register; rx_s = 1 -> rx_valid pulse; rx_s = 0 -> rx_err pulse; both pulses on the clk after the stop sample; never both.
REQ-023 After STOP sample SHALL return to IDLE immediately (mid stop bit), allowing back-to-back frames with zero idle.
REQ-024 After rx_err with line held low (break), SHALL stay IDLE until a new high->low edge.
REQ-025 data SHALL hold its value until the next STOP sample.

Reset
REQ-026 reset SHALL force state IDLE, cnt 0, bit index 0, shift register 0, data 0x00, rx_valid 0, rx_err 0, busy 0.
REQ-027 reset SHALL preset synchronizer flops and edge-detect history to 1, so releasing reset with rx low does not start a frame.
REQ-028 reset mid-frame SHALL abort the frame with no rx_valid/rx_err pulse.

Configuration
REQ-029 Macro CD_RX_GLITCH_FILTER_EN defined: rx_s SHALL be the 3-tap majority of the last three synchronizer outputs, adding 2 clk latency; single-clk glitches are suppressed.
REQ-030 Macro CD_RX_GLITCH_FILTER_EN undefined: rx_s SHALL be the last synchronizer flop output directly; no filter logic present.

Verification
REQ-031 div_ls=9, sel=0, send 0x55 (10 clk/bit, 1 stop) -> exactly one rx_valid, data=0x55, rx_err never high, busy low after pulse.
REQ-032 div_ls=9, low pulse of 3 clk on idle rx -> no rx_valid/rx_err, busy high then low within 10 clk of the pulse end.
REQ-033 div_ls=9, 0xA5 with stop bit 0, then rx held low 50 clk -> one rx_err, data=0xA5, no rx_valid, no second frame until rx rises and falls.
REQ-034 div_hs=3, sel=1, send 0xC3 with sel toggled to 0 at data bit 3 -> rx_valid, data=0xC3.
REQ-035 div_ls=9, 0x00 then 0xFF back-to-back, no idle gap -> two rx_valid pulses, data 0x00 then 0xFF.
REQ-036 reset asserted 1 clk at data bit 4 of a frame -> no pulse, data=0x00, busy=0; next 0x3C frame received correctly.
